rtc_field_editor: RTL and testbench
===================================

RTC_FIELD_EDITOR -- requirements
Module: rtc_field_editor

Interface
REQ-001 Parameter NFIELDS, default 9: number of editable BCD fields (sec, min, hour, day, month, year, alarm sec/min/hour).
REQ-002 Parameter DW, default 8: field and bus data width; must be a multiple of 4.
REQ-003 Parameter AW, default 8: bus address width.
REQ-004 Parameter BASE_ADDR, default 8'h21: bus address of field 0; field i is at BASE_ADDR+i.
REQ-005 Parameters FMIN, FMAX, NFIELDS*DW bits each: packed per-field BCD limits; defaults come from the package.
REQ-006 Parameter TIMEOUT, default 255: maximum wait for bus_done, in cycles.
REQ-007 CLK  in  1  single system clock; all state changes on the rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  rising edge requests an edit session.
REQ-010 commit, abort  in  1 each  rising edge ends the session: commit writes back, abort discards.
REQ-011 up, down, left, right  in  1 each  debounced button levels; internally edge-detected.
REQ-012 bus_rd, bus_wr  out  1 each  bus request; held high until bus_done.
REQ-013 bus_done  in  1  one-cycle pulse completing the current read or write.
REQ-014 bus_addr  out  AW; bus_wdata  out  DW; bus_rdata  in  DW.
REQ-015 cursor  out  clog2(NFIELDS)  index of the selected field.
REQ-016 cur_value  out  DW  BCD value of the field at cursor.
REQ-017 editing  out  1  high in EDIT.
REQ-018 final  out  1  one-cycle pulse on a successful commit.
REQ-019 err  out  1  sticky bus timeout flag; cleared by the next start edge.

Function
REQ-020 FSM states: IDLE, LOAD_REQ, LOAD_WAIT, EDIT, WR_SCAN, WR_WAIT, DONE.
REQ-021 IDLE: a start edge clears err and the index and enters LOAD_REQ; start edges in any other state are ignored.
REQ-022 LOAD: assert bus_rd with bus_addr=BASE_ADDR+i; on bus_done, capture bus_rdata into field[i]; after field NFIELDS-1, go to EDIT with cursor=0 and the dirty mask cleared.
REQ-023 A loaded value that is invalid BCD (any nibble above 9) or outside [FMIN,FMAX] is replaced by FMIN and marks that field dirty.
REQ-024 EDIT, up edge: field[cursor] = BCD+1; at FMAX it wraps to FMIN.
REQ-025 EDIT, down edge: field[cursor] = BCD-1; at FMIN it wraps to FMAX.
REQ-026 Any value change sets dirty[cursor].
REQ-027 Up and down edges in the same cycle: no value change.
REQ-028 Right edge: cursor+1, wrapping NFIELDS-1 to 0. Left edge: cursor-1, wrapping 0 to NFIELDS-1.
REQ-029 Left and right edges in the same cycle: no cursor change.
REQ-030 A value edge and a cursor edge in the same cycle both take effect; the value change applies to the pre-move cursor.
REQ-031 Commit edge: go to WR_SCAN. Abort edge: go to IDLE with no writes. Commit and abort in the same cycle: abort wins. Button edges in that cycle are discarded.
REQ-032 WR_SCAN: step through fields in ascending order, skipping clean fields at one cycle per field.
REQ-033 WR_WAIT: for each dirty field, assert bus_wr with bus_addr=BASE_ADDR+i and bus_wdata=field[i] until bus_done.
REQ-034 After the last field, go to DONE. DONE pulses final for one cycle, then returns to IDLE. A commit with no dirty fields reaches DONE in NFIELDS scan cycles.
REQ-035 Timeout counter runs in LOAD_WAIT and WR_WAIT only; reaching TIMEOUT sets err, deasserts the bus request and returns to IDLE with no further writes.
REQ-036 bus_rd and bus_wr are never high together; each drops the cycle after bus_done.
REQ-037 cur_value and cursor are registered; they are valid in EDIT and hold their last value elsewhere.

Reset
REQ-038 Reset low asynchronously forces IDLE; bus_rd=bus_wr=0, bus_addr=0, bus_wdata=0, cursor=0, cur_value=0, editing=0, final=0, err=0; all fields are set to FMIN, dirty mask and edge-detect registers cleared.
REQ-039 Reset mid-transaction abandons the transaction; no partial-session state survives.

Structure
REQ-040 Package rtc_edit_pkg holds the state enum, default FMIN/FMAX vectors (00-59, 00-59, 00-23, 01-31, 01-12, 00-99, 00-59, 00-59, 00-23) and the BASE_ADDR default.
REQ-041 Sub-module bcd_step: combinational DW-bit BCD +/-1 with min/max wrap, instantiated once and shared by the cursor field.

Verification
REQ-042 Start; bus returns 0x45,0x30,0x12,0x15,0x09,0x16,0,0,0 -> editing=1, cursor=0, cur_value=0x45, 9 reads at addresses 0x21..0x29.
REQ-043 Field 0 = 0x59, one up edge -> 0x00; one down edge -> 0x59. Field 3 = 0x01, one down edge -> 0x31.
REQ-044 Cursor=0, left edge -> cursor=8. Up+down edges in the same cycle -> value unchanged. Up+right in the same cycle -> field 0 incremented, cursor=1.
REQ-045 Edit fields 2 and 5, then commit -> exactly 2 writes (0x23, 0x26) in that order, then a final pulse; abort instead -> no bus_wr, no final.
REQ-046 Load reads 0x7A for field 0 -> field 0 = 0x00, and it is written on commit.
REQ-047 Hold bus_done low for 255 cycles in WR_WAIT -> err=1, IDLE, bus_wr=0; reset asserted during LOAD_WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/rtc_field_editor_pkg.sv
// Shared types and defaults for the RTC field editor: FSM encoding, per-field
// BCD limits (field 0 in the least significant byte) and the default bus base.
package rtc_edit_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_REQ,
        S_LOAD_WAIT,
        S_EDIT,
        S_WR_SCAN,
        S_WR_WAIT,
        S_DONE
    } state_t;

    // sec, min, hour, day, month, year, alarm sec, alarm min, alarm hour
    localparam logic [71:0] FMIN_DEFAULT = 72'h00_00_00_00_01_01_00_00_00;
    localparam logic [71:0] FMAX_DEFAULT = 72'h23_59_59_99_12_31_23_59_59;
    localparam logic [7:0]  BASE_ADDR_DEFAULT = 8'h21;

    function automatic logic bcd_ok(input logic [63:0] v, input int unsigned nibbles);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < nibbles && v[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/rtc_field_editor_if.sv
// Register-bus handshake between the field editor (master) and the RTC register file.
interface rtc_field_editor_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          bus_rd;
    logic          bus_wr;
    logic          bus_done;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;

    modport master (
        output bus_rd, bus_wr, bus_addr, bus_wdata,
        input  bus_done, bus_rdata
    );

    modport slave (
        input  bus_rd, bus_wr, bus_addr, bus_wdata,
        output bus_done, bus_rdata
    );
endinterface

// File: rtl/rtc_field_editor_bcd_step.sv
// Combinational multi-digit BCD increment/decrement with wrap between fmin and fmax.
module bcd_step #(
    parameter int unsigned DW = 8
) (
    input  logic [DW-1:0] value,
    input  logic [DW-1:0] fmin,
    input  logic [DW-1:0] fmax,
    input  logic          inc,
    input  logic          dec,
    output logic [DW-1:0] result
);
    localparam int unsigned ND = DW / 4;

    logic [DW-1:0] plus;
    logic [DW-1:0] minus;
    logic          carry;
    logic          borrow;

    always_comb begin
        plus   = value;
        minus  = value;
        carry  = 1'b1;
        borrow = 1'b1;
        for (int unsigned i = 0; i < ND; i++) begin
            if (carry) begin
                if (value[i*4 +: 4] >= 4'd9) begin
                    plus[i*4 +: 4] = 4'd0;
                end else begin
                    plus[i*4 +: 4] = value[i*4 +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (value[i*4 +: 4] == 4'd0) begin
                    minus[i*4 +: 4] = 4'd9;
                end else begin
                    minus[i*4 +: 4] = value[i*4 +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end

        result = value;
        if (inc && !dec) begin
            result = (value == fmax) ? fmin : plus;
        end else if (dec && !inc) begin
            result = (value == fmin) ? fmax : minus;
        end
    end
endmodule

// File: rtl/rtc_field_editor.sv
// Button-driven RTC field editor: loads all BCD fields over the register bus,
// edits them with up/down/left/right, and writes back only the dirty fields.
module rtc_field_editor
    import rtc_edit_pkg::*;
#(
    parameter int unsigned             NFIELDS   = 9,
    parameter int unsigned             DW        = 8,
    parameter int unsigned             AW        = 8,
    parameter logic [AW-1:0]           BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter logic [NFIELDS*DW-1:0]   FMIN      = FMIN_DEFAULT,
    parameter logic [NFIELDS*DW-1:0]   FMAX      = FMAX_DEFAULT,
    parameter int unsigned             TIMEOUT   = 255,
    localparam int unsigned            CW        = (NFIELDS > 1) ? $clog2(NFIELDS) : 1
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 commit,
    input  logic                 abort,
    input  logic                 up,
    input  logic                 down,
    input  logic                 left,
    input  logic                 right,
    rtc_field_editor_if.master   bus,
    output logic [CW-1:0]        cursor,
    output logic [DW-1:0]        cur_value,
    output logic                 editing,
    output logic                 final_pulse,
    output logic                 err
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_t state, state_next;

    logic [DW-1:0]      field [NFIELDS];
    logic [NFIELDS-1:0] dirty;
    logic [CW-1:0]      idx;
    logic [CW-1:0]      cursor_next;
    logic [TW-1:0]      tmo;

    logic start_q, commit_q, abort_q, up_q, down_q, left_q, right_q;
    logic start_e, commit_e, abort_e, up_e, down_e, left_e, right_e;

    logic [DW-1:0] fmin_idx, fmax_idx, fmin_cur, fmax_cur;
    logic [DW-1:0] rd_fixed, step_val, cur_next;
    logic          rd_ok, last, tmo_hit;

    assign start_e  = start  & ~start_q;
    assign commit_e = commit & ~commit_q;
    assign abort_e  = abort  & ~abort_q;
    assign up_e     = up     & ~up_q;
    assign down_e   = down   & ~down_q;
    assign left_e   = left   & ~left_q;
    assign right_e  = right  & ~right_q;

    assign fmin_idx = FMIN[idx*DW +: DW];
    assign fmax_idx = FMAX[idx*DW +: DW];
    assign fmin_cur = FMIN[cursor*DW +: DW];
    assign fmax_cur = FMAX[cursor*DW +: DW];

    assign rd_ok    = bcd_ok(64'(bus.bus_rdata), DW / 4)
                      && (bus.bus_rdata >= fmin_idx) && (bus.bus_rdata <= fmax_idx);
    assign rd_fixed = rd_ok ? bus.bus_rdata : fmin_idx;
    assign last     = (idx == CW'(NFIELDS - 1));
    assign tmo_hit  = (tmo == TW'(TIMEOUT - 1)) && !bus.bus_done;

    bcd_step #(.DW(DW)) u_step (
        .value  (field[cursor]),
        .fmin   (fmin_cur),
        .fmax   (fmax_cur),
        .inc    (up_e),
        .dec    (down_e),
        .result (step_val)
    );

    // The value step applies to the pre-move cursor; if the cursor stays put
    // the displayed value must reflect that step immediately.
    always_comb begin
        cursor_next = cursor;
        if (right_e && !left_e) begin
            cursor_next = (cursor == CW'(NFIELDS - 1)) ? '0 : cursor + 1'b1;
        end else if (left_e && !right_e) begin
            cursor_next = (cursor == '0) ? CW'(NFIELDS - 1) : cursor - 1'b1;
        end
        cur_next = (cursor_next == cursor) ? step_val : field[cursor_next];
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (start_e) state_next = S_LOAD_REQ;
            S_LOAD_REQ:  state_next = S_LOAD_WAIT;
            S_LOAD_WAIT: begin
                if (bus.bus_done) state_next = last ? S_EDIT : S_LOAD_REQ;
                else if (tmo_hit) state_next = S_IDLE;
            end
            S_EDIT: begin
                if (abort_e)       state_next = S_IDLE;
                else if (commit_e) state_next = S_WR_SCAN;
            end
            S_WR_SCAN: begin
                if (dirty[idx]) state_next = S_WR_WAIT;
                else if (last)  state_next = S_DONE;
            end
            S_WR_WAIT: begin
                if (bus.bus_done) state_next = last ? S_DONE : S_WR_SCAN;
                else if (tmo_hit) state_next = S_IDLE;
            end
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            bus.bus_rd    <= 1'b0;
            bus.bus_wr    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            cursor        <= '0;
            cur_value     <= '0;
            editing       <= 1'b0;
            final_pulse   <= 1'b0;
            err           <= 1'b0;
            dirty         <= '0;
            idx           <= '0;
            tmo           <= '0;
            {start_q, commit_q, abort_q, up_q, down_q, left_q, right_q} <= '0;
            for (int unsigned i = 0; i < NFIELDS; i++) field[i] <= FMIN[i*DW +: DW];
        end else begin
            {start_q, commit_q, abort_q, up_q, down_q, left_q, right_q}
                <= {start, commit, abort, up, down, left, right};
            editing     <= (state_next == S_EDIT);
            final_pulse <= (state_next == S_DONE);

            case (state)
                S_IDLE: begin
                    if (start_e) begin
                        err   <= 1'b0;
                        idx   <= '0;
                        dirty <= '0;
                    end
                end
                S_LOAD_REQ: begin
                    bus.bus_rd   <= 1'b1;
                    bus.bus_addr <= BASE_ADDR + AW'(idx);
                    tmo          <= '0;
                end
                S_LOAD_WAIT: begin
                    if (bus.bus_done) begin
                        bus.bus_rd <= 1'b0;
                        field[idx] <= rd_fixed;
                        if (!rd_ok) dirty[idx] <= 1'b1;
                        if (last) begin
                            cursor    <= '0;
                            cur_value <= (idx == '0) ? rd_fixed : field[0];
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        err        <= 1'b1;
                        bus.bus_rd <= 1'b0;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_EDIT: begin
                    if (commit_e || abort_e) begin
                        idx <= '0;
                    end else begin
                        if (step_val != field[cursor]) begin
                            field[cursor] <= step_val;
                            dirty[cursor] <= 1'b1;
                        end
                        cursor    <= cursor_next;
                        cur_value <= cur_next;
                    end
                end
                S_WR_SCAN: begin
                    if (dirty[idx]) begin
                        bus.bus_wr    <= 1'b1;
                        bus.bus_addr  <= BASE_ADDR + AW'(idx);
                        bus.bus_wdata <= field[idx];
                        tmo           <= '0;
                    end else if (!last) begin
                        idx <= idx + 1'b1;
                    end
                end
                S_WR_WAIT: begin
                    if (bus.bus_done) begin
                        bus.bus_wr <= 1'b0;
                        if (!last) idx <= idx + 1'b1;
                    end else if (tmo_hit) begin
                        err        <= 1'b1;
                        bus.bus_wr <= 1'b0;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rtc_field_editor.sv
// Bench for rtc_field_editor: bus responder with read/write scoreboards plus
// directed button sequences for editing, commit, abort, timeout and reset.
module tb_rtc_field_editor;

    localparam logic [6:0] B_START  = 7'b1000000;
    localparam logic [6:0] B_COMMIT = 7'b0100000;
    localparam logic [6:0] B_ABORT  = 7'b0010000;
    localparam logic [6:0] B_UP     = 7'b0001000;
    localparam logic [6:0] B_DOWN   = 7'b0000100;
    localparam logic [6:0] B_LEFT   = 7'b0000010;
    localparam logic [6:0] B_RIGHT  = 7'b0000001;

    localparam logic [71:0] V1 = 72'h00_00_00_16_09_15_12_30_45;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] btn;
    logic [3:0] cursor;
    logic [7:0] cur_value;
    logic       editing, final_pulse, err;

    always #5 clk = ~clk;

    rtc_field_editor_if #(.AW(8), .DW(8)) bus_if ();

    rtc_field_editor #(
        .NFIELDS   (9),
        .DW        (8),
        .AW        (8),
        .BASE_ADDR (8'h21),
        .TIMEOUT   (255)
    ) dut (
        .CLK         (clk),
        .reset       (rst_n),
        .start       (btn[6]),
        .commit      (btn[5]),
        .abort       (btn[4]),
        .up          (btn[3]),
        .down        (btn[2]),
        .left        (btn[1]),
        .right       (btn[0]),
        .bus         (bus_if),
        .cursor      (cursor),
        .cur_value   (cur_value),
        .editing     (editing),
        .final_pulse (final_pulse),
        .err         (err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_reads = 0;
    int n_writes = 0;
    int n_final = 0;
    int wr_hi = 0;
    int lat = 0;
    bit hold_done = 1'b0;

    logic [7:0]  mem [256];
    logic [7:0]  exp_rd [$];
    logic [15:0] exp_wr [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus slave: two-cycle latency, one-cycle done pulse, scoreboarded transfers.
    initial begin
        logic [31:0] exp;
        bus_if.bus_done  = 1'b0;
        bus_if.bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (final_pulse) n_final++;
            if (bus_if.bus_wr) wr_hi++;
            if (bus_if.bus_done) begin
                bus_if.bus_done = 1'b0;
            end else if (rst_n && (bus_if.bus_rd || bus_if.bus_wr) && !hold_done) begin
                lat++;
                if (lat >= 2) begin
                    lat = 0;
                    check_eq("rd_wr_excl", 32'(bus_if.bus_rd & bus_if.bus_wr), 0);
                    bus_if.bus_done = 1'b1;
                    if (bus_if.bus_rd) begin
                        n_reads++;
                        bus_if.bus_rdata = mem[bus_if.bus_addr];
                        exp = (exp_rd.size() > 0) ? 32'(exp_rd.pop_front()) : 32'hDEAD;
                        check_eq("rd_addr", 32'(bus_if.bus_addr), exp);
                    end else begin
                        n_writes++;
                        exp = (exp_wr.size() > 0) ? 32'(exp_wr.pop_front()) : 32'hDEAD_0000;
                        check_eq("wr_addr_data", {16'h0, bus_if.bus_addr, bus_if.bus_wdata}, exp);
                    end
                end
            end else begin
                lat = 0;
            end
        end
    end

    task automatic press(input logic [6:0] m);
        @(negedge clk); btn = m;
        @(negedge clk); btn = '0;
        @(negedge clk);
    endtask

    task automatic load(input logic [71:0] v);
        for (int i = 0; i < 9; i++) begin
            mem[8'h21 + i] = v[i*8 +: 8];
            exp_rd.push_back(8'(8'h21 + i));
        end
        press(B_START);
        for (int i = 0; i < 400 && !editing; i++) @(negedge clk);
        check_eq("edit_entry", 32'(editing), 1);
    endtask

    task automatic wait_final(input int f0);
        for (int i = 0; i < 400 && n_final == f0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, w0, r0, nw0;
        btn   = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_bus_rd", 32'(bus_if.bus_rd), 0);
        check_eq("rst_bus_wr", 32'(bus_if.bus_wr), 0);
        check_eq("rst_bus_addr", 32'(bus_if.bus_addr), 0);
        check_eq("rst_bus_wdata", 32'(bus_if.bus_wdata), 0);
        check_eq("rst_cursor", 32'(cursor), 0);
        check_eq("rst_cur_value", 32'(cur_value), 0);
        check_eq("rst_editing", 32'(editing), 0);
        check_eq("rst_final", 32'(final_pulse), 0);
        check_eq("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Load of the reference pattern
        r0 = n_reads;
        load(V1);
        check_eq("load_cursor", 32'(cursor), 0);
        check_eq("load_cur_value", 32'(cur_value), 32'h45);
        check_eq("load_nreads", 32'(n_reads - r0), 9);
        check_eq("load_rd_q_empty", 32'(exp_rd.size()), 0);
        press(B_ABORT);

        // Wrap at FMAX/FMIN, then abort discards edits
        load(72'h00_00_00_16_09_01_12_30_59);
        press(B_UP);
        check_eq("up_wrap_59", 32'(cur_value), 32'h00);
        press(B_DOWN);
        check_eq("down_wrap_00", 32'(cur_value), 32'h59);
        repeat (3) press(B_RIGHT);
        check_eq("right3_cursor", 32'(cursor), 3);
        check_eq("field3_value", 32'(cur_value), 32'h01);
        press(B_DOWN);
        check_eq("day_wrap_01", 32'(cur_value), 32'h31);
        w0 = wr_hi; f0 = n_final;
        press(B_ABORT);
        repeat (20) @(negedge clk);
        check_eq("abort_no_wr", 32'(wr_hi - w0), 0);
        check_eq("abort_no_final", 32'(n_final - f0), 0);
        check_eq("abort_idle", 32'(editing), 0);

        // Cursor wrap and simultaneous button edges
        load(V1);
        press(B_LEFT);
        check_eq("left_wrap_cursor", 32'(cursor), 8);
        check_eq("left_wrap_value", 32'(cur_value), 32'h00);
        press(B_RIGHT);
        check_eq("right_wrap_cursor", 32'(cursor), 0);
        press(B_UP | B_DOWN);
        check_eq("up_down_same", 32'(cur_value), 32'h45);
        press(B_LEFT | B_RIGHT);
        check_eq("left_right_same", 32'(cursor), 0);
        press(B_UP | B_RIGHT);
        check_eq("up_right_cursor", 32'(cursor), 1);
        check_eq("up_right_value", 32'(cur_value), 32'h30);
        press(B_LEFT);
        check_eq("up_right_field0", 32'(cur_value), 32'h46);
        press(B_ABORT);

        // Edit fields 2 and 5 then commit
        load(V1);
        repeat (2) press(B_RIGHT);
        check_eq("f2_value", 32'(cur_value), 32'h12);
        press(B_UP);
        check_eq("f2_inc", 32'(cur_value), 32'h13);
        repeat (3) press(B_RIGHT);
        check_eq("f5_cursor", 32'(cursor), 5);
        press(B_UP);
        check_eq("f5_inc", 32'(cur_value), 32'h17);
        exp_wr.push_back(16'h23_13);
        exp_wr.push_back(16'h26_17);
        f0 = n_final; nw0 = n_writes;
        press(B_COMMIT);
        wait_final(f0);
        check_eq("commit_nwrites", 32'(n_writes - nw0), 2);
        check_eq("commit_final", 32'(n_final - f0), 1);
        check_eq("commit_wr_q_empty", 32'(exp_wr.size()), 0);
        check_eq("commit_err", 32'(err), 0);

        // Invalid BCD and out-of-range month are sanitised and written back
        load(72'h00_00_00_16_13_15_12_30_7A);
        check_eq("sanitise_f0", 32'(cur_value), 32'h00);
        exp_wr.push_back(16'h21_00);
        exp_wr.push_back(16'h25_01);
        f0 = n_final;
        press(B_COMMIT);
        wait_final(f0);
        check_eq("sanitise_final", 32'(n_final - f0), 1);
        check_eq("sanitise_wr_q_empty", 32'(exp_wr.size()), 0);

        // Write timeout
        load(V1);
        press(B_UP);
        check_eq("tmo_edit", 32'(cur_value), 32'h46);
        hold_done = 1'b1;
        w0 = wr_hi; f0 = n_final;
        press(B_COMMIT);
        for (int i = 0; i < 600 && !err; i++) @(negedge clk);
        check_eq("tmo_err", 32'(err), 1);
        repeat (2) @(negedge clk);
        check_eq("tmo_wr_cycles", 32'(wr_hi - w0), 255);
        check_eq("tmo_bus_wr", 32'(bus_if.bus_wr), 0);
        check_eq("tmo_editing", 32'(editing), 0);
        check_eq("tmo_no_final", 32'(n_final - f0), 0);
        hold_done = 1'b0;
        load(V1);
        check_eq("err_cleared", 32'(err), 0);
        press(B_ABORT);

        // Reset during LOAD_WAIT
        hold_done = 1'b1;
        mem[8'h21] = 8'h45;
        press(B_START);
        for (int i = 0; i < 50 && !bus_if.bus_rd; i++) @(negedge clk);
        check_eq("lw_bus_rd", 32'(bus_if.bus_rd), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("lw_rst_bus_rd", 32'(bus_if.bus_rd), 0);
        check_eq("lw_rst_bus_addr", 32'(bus_if.bus_addr), 0);
        check_eq("lw_rst_cursor", 32'(cursor), 0);
        check_eq("lw_rst_cur_value", 32'(cur_value), 0);
        check_eq("lw_rst_editing", 32'(editing), 0);
        check_eq("lw_rst_err", 32'(err), 0);
        exp_rd.delete();
        @(negedge clk);
        rst_n = 1'b1;
        hold_done = 1'b0;
        repeat (2) @(negedge clk);
        load(V1);
        check_eq("recover_value", 32'(cur_value), 32'h45);
        press(B_ABORT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
